mem_bank_sram: RTL

Single-port, byte-writable SRAM bank that sits directly downstream of `axi_to_mem_sv` and serves one of its `NumBanks` memory ports. It accepts the same `req/addr/wdata/we` stream that the AXI-to-memory converter emits. It returns read data after a fixed, parameterised latency with no backpressure, so `Latency` must equal the converter's `BufDepth`. An optional post-reset zero-fill sweep is compiled in by macro.

---
 rtl/mem_bank_pkg.sv | 24 ++
 rtl/mem_bank_rd_pipe.sv | 62 ++++++
 rtl/mem_bank_sram.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_bank_pkg.sv
// Shared types and width helpers for the single-port byte-writable SRAM bank.
package mem_bank_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_bank_state_e;

  // Byte-offset bits below the word index for a given bank data width.
  function automatic int unsigned offset_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Word-index bits for a given array depth.
  function automatic int unsigned index_width(input int unsigned num_words);
    return $clog2(num_words);
  endfunction

  localparam int unsigned DefDataWidth   = 32;
  localparam int unsigned DefNumWords    = 1024;
  localparam int unsigned DefOffsetWidth = offset_width(DefDataWidth);
  localparam int unsigned DefIndexWidth  = index_width(DefNumWords);

endpackage

// File: rtl/mem_bank_rd_pipe.sv
// Read-data delay line: Latency-1 shift stages followed by an output register
// that only updates when a read completes, so the last result is held.
module mem_bank_rd_pipe #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  output logic [DataWidth-1:0] out_data_o
);

  logic                 last_valid;
  logic [DataWidth-1:0] last_data;
  logic                 out_valid_q;
  logic [DataWidth-1:0] out_data_q;

  if (Latency > 1) begin : g_delay
    logic [Latency-2:0][DataWidth-1:0] data_q;
    logic [Latency-2:0]                valid_q;

    // Plain shift register for data and valid; reset drops in-flight reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        data_q[0]  <= in_data_i;
        valid_q[0] <= in_valid_i;
        for (int unsigned i = 1; i < Latency - 1; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign last_valid = valid_q[Latency-2];
    assign last_data  = data_q[Latency-2];
  end else begin : g_direct
    assign last_valid = in_valid_i;
    assign last_data  = in_data_i;
  end

  // Output register: pulse valid per result, hold data between results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= last_valid;
      if (last_valid) begin
        out_data_q <= last_data;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/mem_bank_sram.sv
// Single-port byte-writable SRAM bank with fixed read latency, fed by the
// AXI-to-memory converter. Optional post-reset zero-fill sweep is compiled in
// with MEM_BANK_SRAM_INIT_EN.
module mem_bank_sram
  import mem_bank_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned NumWords  = DefNumWords,
  parameter int unsigned Latency   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mem_req_i,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_we_i,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_rvalid_o,
  output logic                   init_done_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffW     = offset_width(DataWidth);
  localparam int unsigned IdxW     = index_width(NumWords);

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [IdxW-1:0]      idx;
  mem_bank_state_e      state_q;
  logic                 ready;
  logic                 rd_en;
  logic                 init_wr;
  logic [IdxW-1:0]      init_idx;
  logic                 wr_en;
  logic [IdxW-1:0]      wr_idx;
  logic [DataWidth-1:0] wr_data;
  logic [NumBytes-1:0]  wr_be;
  logic                 unused_addr;

  // Offset bits and bits above the index are ignored, so addresses wrap.
  assign idx         = mem_addr_i[OffW +: IdxW];
  assign unused_addr = ^mem_addr_i;

`ifdef MEM_BANK_SRAM_INIT_EN
  localparam logic [IdxW:0] LastWord = (IdxW + 1)'(NumWords - 1);

  logic [IdxW:0] init_cnt_q;
  logic          init_done_q;
  logic          unused_cnt_msb;

  // Init FSM: sweep zeros through every word, then serve traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LastWord) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
          end
        end
        READY:   state_q <= READY;
        default: state_q <= INIT;
      endcase
    end
  end

  assign init_done_o    = init_done_q;
  assign init_wr        = (state_q == INIT);
  assign init_idx       = init_cnt_q[IdxW-1:0];
  assign unused_cnt_msb = init_cnt_q[IdxW];
`else
  assign state_q     = READY;
  assign init_done_o = 1'b1;
  assign init_wr     = 1'b0;
  assign init_idx    = '0;
`endif

  assign ready = (state_q == READY);
  assign rd_en = ready && mem_req_i && (mem_we_i == '0);

  // Select the write source: the zero-fill sweep or a strobed request.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = mem_wdata_i;
    wr_be   = mem_we_i;
    if (init_wr) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx;
      wr_data = '0;
      wr_be   = '1;
    end else if (ready && mem_req_i && (|mem_we_i)) begin
      wr_en = 1'b1;
    end
  end

  // Array write with per-byte enables; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  mem_bank_rd_pipe #(
    .DataWidth (DataWidth),
    .Latency   (Latency)
  ) u_rd_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (rd_en),
    .in_data_i   (mem_q[idx]),
    .out_valid_o (mem_rvalid_o),
    .out_data_o  (mem_rdata_o)
  );

endmodule
